// File: rtl/prim_lc_tx_sender.sv
`default_nettype none
// ============================================================================
// Module      : prim_lc_tx_sender
// Description : Source-side driver for a 4-bit life-cycle multibit enable.
//               Drives a fully registered lc_en_o toward a remote
//               synchronizer, waits for the echoed value to come back, and
//               reports completion. A watchdog forces Off and latches an
//               error when the echo never arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_lc_tx_sender #(
    parameter bit          ResetValueIsOn = 1'b0,
    parameter bit          StickyOn       = 1'b0,
    parameter bit          AckSyncOn      = 1'b1,
    parameter int unsigned Timeout        = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       en_i,
    input  logic [3:0] ack_i,
    output logic [3:0] lc_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0]  C_LC_ON    = 4'b0101;
    localparam logic [3:0]  C_LC_OFF   = 4'b1010;
    localparam logic [3:0]  C_LC_RESET = ResetValueIsOn ? C_LC_ON : C_LC_OFF;
    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam int unsigned C_CNT_W    = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(Timeout);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic [3:0]           r_lc_en;
    logic [3:0]           w_lc_en_d;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_d;
    logic                 r_done;
    logic                 w_done_d;
    logic                 r_err;
    logic                 w_err_d;
    logic [3:0]           w_target;
    logic [3:0]           w_ack_s;

    generate
        if (AckSyncOn) begin : g_ack_sync
            logic [3:0] r_ack_sync;
            // Capture register bringing the echo into this clock domain; its
            // single cycle of latency is what the completion timing is built on.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_ack_sync <= C_LC_RESET;
                end else begin
                    r_ack_sync <= ack_i;
                end
            end
            assign w_ack_s = r_ack_sync;
        end else begin : g_ack_direct
            // Echo already lives in this clock domain.
            assign w_ack_s = ack_i;
        end
    endgenerate

    // State, output enable, watchdog counter and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_lc_en <= C_LC_RESET;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_lc_en <= w_lc_en_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

    // Next-state logic: accept requests in Idle, wait for the echo, trip on timeout.
    always_comb begin
        w_state_d = r_state;
        w_lc_en_d = r_lc_en;
        w_cnt_d   = r_cnt;
        w_done_d  = 1'b0;
        w_err_d   = r_err;
        w_target  = en_i ? C_LC_ON : C_LC_OFF;

        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (StickyOn && (r_lc_en == C_LC_ON) && (w_target == C_LC_OFF)) begin
                        // Refused: once On, the enable stays On until reset.
                        w_done_d = 1'b1;
                    end else if (w_target == r_lc_en) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_lc_en_d = w_target;
                        w_cnt_d   = '0;
                        w_state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (w_ack_s == r_lc_en) begin
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end else if ((Timeout != 0) && (r_cnt == C_CNT_MAX)) begin
                    w_state_d = ST_ERROR;
                    w_lc_en_d = C_LC_OFF;
                    w_err_d   = 1'b1;
                end else if (Timeout != 0) begin
                    // Compare happens before increment, so the counter never wraps.
                    w_cnt_d = r_cnt + C_CNT_W'(1);
                end
            end

            ST_ERROR: begin
                w_lc_en_d = C_LC_OFF;
                w_err_d   = 1'b1;
            end

            default: begin
                // Unreachable encoding: fail safe into the terminal error state.
                w_state_d = ST_ERROR;
                w_lc_en_d = C_LC_OFF;
                w_err_d   = 1'b1;
            end
        endcase
    end

    assign lc_en_o = r_lc_en;
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prim_lc_tx_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_prim_lc_tx_sender
// Description : Directed self-checking bench for prim_lc_tx_sender. Three
//               instances cover synchronized echo with a short watchdog,
//               sticky-On behaviour, and direct echo with the watchdog off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prim_lc_tx_sender;

    localparam logic [3:0] C_ON  = 4'b0101;
    localparam logic [3:0] C_OFF = 4'b1010;

    typedef struct {
        int         cyc;
        logic [3:0] lc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    logic       req_a = 1'b0, en_a = 1'b0, loop_a = 1'b0;
    logic       req_b = 1'b0, en_b = 1'b0, loop_b = 1'b0;
    logic       req_c = 1'b0, en_c = 1'b0, loop_c = 1'b1;
    logic [3:0] ackdrv_a = C_OFF, ackdrv_b = C_OFF, ackdrv_c = C_OFF;
    logic [3:0] ack_a, ack_b, ack_c;
    logic [3:0] lc_a, lc_b, lc_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       err_a, err_b, err_c;

    ev_t exp_a[$];
    ev_t exp_b[$];
    ev_t exp_c[$];
    ev_t ea, eb, ec;

    assign ack_a = loop_a ? lc_a : ackdrv_a;
    assign ack_b = loop_b ? lc_b : ackdrv_b;
    assign ack_c = loop_c ? lc_c : ackdrv_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prim_lc_tx_sender #(.ResetValueIsOn(1'b0), .StickyOn(1'b0), .AckSyncOn(1'b1), .Timeout(4))
    u_dut_a (.clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .en_i(en_a), .ack_i(ack_a),
             .lc_en_o(lc_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

    prim_lc_tx_sender #(.ResetValueIsOn(1'b0), .StickyOn(1'b1), .AckSyncOn(1'b1), .Timeout(255))
    u_dut_b (.clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .en_i(en_b), .ack_i(ack_b),
             .lc_en_o(lc_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

    prim_lc_tx_sender #(.ResetValueIsOn(1'b1), .StickyOn(1'b0), .AckSyncOn(1'b0), .Timeout(0))
    u_dut_c (.clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .en_i(en_c), .ack_i(ack_c),
             .lc_en_o(lc_c), .busy_o(busy_c), .done_o(done_c), .err_o(err_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the accepting edge is the next posedge (cycle N).
    // dly >= 0 pushes an expected done pulse at cycle N+dly carrying value lc.
    task automatic do_req(input int id, input logic en, input int dly, input logic [3:0] lc);
        ev_t e;
        e.cyc = cyc + 1 + dly;
        e.lc  = lc;
        case (id)
            0: begin req_a = 1'b1; en_a = en; if (dly >= 0) exp_a.push_back(e); end
            1: begin req_b = 1'b1; en_b = en; if (dly >= 0) exp_b.push_back(e); end
            default: begin req_c = 1'b1; en_c = en; if (dly >= 0) exp_c.push_back(e); end
        endcase
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
    endtask

    // Scoreboards: each cycle either an expected done pulse is due, or done must be low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_a.size() > 0 && exp_a[0].cyc == cyc) begin
                ea = exp_a.pop_front();
                chk("a_done", done_a, 1'b1);
                chk("a_done_lc", lc_a, ea.lc);
            end else chk("a_no_done", done_a, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_b.size() > 0 && exp_b[0].cyc == cyc) begin
                eb = exp_b.pop_front();
                chk("b_done", done_b, 1'b1);
                chk("b_done_lc", lc_b, eb.lc);
            end else chk("b_no_done", done_b, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_c.size() > 0 && exp_c[0].cyc == cyc) begin
                ec = exp_c.pop_front();
                chk("c_done", done_c, 1'b1);
                chk("c_done_lc", lc_c, ec.lc);
            end else chk("c_no_done", done_c, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        ev_t e;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_lc_a", lc_a, C_OFF);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_lc_b", lc_b, C_OFF);
        chk("rst_lc_c", lc_c, C_ON);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: loopback On request, done at N+2
        loop_a = 1'b1;
        do_req(0, 1'b1, 2, C_ON);
        chk("a_on_lc", lc_a, C_ON);
        chk("a_on_busy_n", busy_a, 1'b1);
        @(negedge clk);
        chk("a_on_busy_n1", busy_a, 1'b1);
        @(negedge clk);
        chk("a_on_busy_n2", busy_a, 1'b0);
        repeat (2) @(negedge clk);

        // A: loopback Off request
        do_req(0, 1'b0, 2, C_OFF);
        chk("a_off_lc", lc_a, C_OFF);
        repeat (4) @(negedge clk);

        // A: no-change request, done in the accept cycle only
        do_req(0, 1'b0, 0, C_OFF);
        chk("a_nochg_busy", busy_a, 1'b0);
        chk("a_nochg_lc", lc_a, C_OFF);
        @(negedge clk);
        chk("a_nochg_busy1", busy_a, 1'b0);
        repeat (2) @(negedge clk);

        // A: timeout with echo stuck at Off
        loop_a   = 1'b0;
        ackdrv_a = C_OFF;
        do_req(0, 1'b1, -1, C_ON);
        chk("a_to_lc", lc_a, C_ON);
        repeat (4) @(negedge clk);
        chk("a_to_err_n4", err_a, 1'b0);
        chk("a_to_busy_n4", busy_a, 1'b1);
        chk("a_to_lc_n4", lc_a, C_ON);
        @(negedge clk);
        chk("a_to_err_n5", err_a, 1'b1);
        chk("a_to_lc_n5", lc_a, C_OFF);
        chk("a_to_busy_n5", busy_a, 1'b1);
        do_req(0, 1'b1, -1, C_ON);
        repeat (2) @(negedge clk);
        chk("a_err_hold_lc", lc_a, C_OFF);
        chk("a_err_hold_err", err_a, 1'b1);
        chk("a_err_hold_busy", busy_a, 1'b1);

        // A: reset out of Error, then reset in the middle of Wait
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("a_rst_err", err_a, 1'b0);
        do_req(0, 1'b1, -1, C_ON);
        @(negedge clk);
        chk("a_mid_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("a_async_lc", lc_a, C_OFF);
        chk("a_async_busy", busy_a, 1'b0);
        chk("a_async_done", done_a, 1'b0);
        chk("a_async_err", err_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loop_a = 1'b1;
        do_req(0, 1'b1, 2, C_ON);
        chk("a_post_lc", lc_a, C_ON);
        repeat (4) @(negedge clk);

        // B: echo passes through invalid values before matching
        loop_b   = 1'b0;
        ackdrv_b = C_OFF;
        do_req(1, 1'b1, 5, C_ON);
        ackdrv_b = 4'b0000;
        @(negedge clk);
        ackdrv_b = 4'b1111;
        @(negedge clk);
        ackdrv_b = 4'b0000;
        @(negedge clk);
        ackdrv_b = C_ON;
        chk("b_inv_busy3", busy_b, 1'b1);
        @(negedge clk);
        chk("b_inv_busy4", busy_b, 1'b1);
        @(negedge clk);
        chk("b_inv_busy5", busy_b, 1'b0);
        loop_b = 1'b1;
        repeat (2) @(negedge clk);

        // B: sticky On refuses an Off request
        do_req(1, 1'b0, 0, C_ON);
        chk("b_sticky_lc", lc_b, C_ON);
        chk("b_sticky_busy", busy_b, 1'b0);
        repeat (2) @(negedge clk);
        chk("b_sticky_lc2", lc_b, C_ON);

        // C: direct echo, match one edge after accept
        do_req(2, 1'b0, 1, C_OFF);
        chk("c_off_lc", lc_c, C_OFF);
        chk("c_off_busy_n", busy_c, 1'b1);
        @(negedge clk);
        chk("c_off_busy_n1", busy_c, 1'b0);
        repeat (2) @(negedge clk);

        // C: watchdog disabled, long wait never errors
        loop_c   = 1'b0;
        ackdrv_c = C_OFF;
        do_req(2, 1'b1, -1, C_ON);
        repeat (8) @(negedge clk);
        chk("c_nowd_err", err_c, 1'b0);
        chk("c_nowd_busy", busy_c, 1'b1);
        e.cyc = cyc + 1;
        e.lc  = C_ON;
        exp_c.push_back(e);
        loop_c = 1'b1;
        @(negedge clk);
        chk("c_late_busy", busy_c, 1'b0);
        repeat (2) @(negedge clk);

        chk("a_queue_empty", exp_a.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        chk("c_queue_empty", exp_c.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
